uart_tx: RTL and testbench
==========================

# uart_tx

Buffered 8N1 UART transmitter: the transmit-side counterpart of the byte receiver behind `uart_loopback`'s `i_rx`. It accepts bytes from on-chip logic over a valid/ready handshake, queues them in a small FIFO, and serialises them LSB-first on `o_tx` at a fixed baud set by a clock divisor. It drives the board TX pin and feeds the serial side of loopback benches.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200 ≈ 104); must be ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_data`  in  8  byte to transmit.
- `i_valid`  in  1  `i_data` valid.
- `o_ready`  out  1  FIFO can accept a byte; high when FIFO not full.
- `o_tx`  out  1  serial line, idle high; registered output.
- `o_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `o_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: `o_tx`=1, `o_busy`=0, `o_ready`=1, `o_count`=0; FSM=IDLE; FIFO pointers, bit counter and baud counter cleared.
- Push: a byte is written when `i_valid && o_ready` at a rising edge. If `o_ready`=0, `i_data` is ignored and not stored; no error flag.
- `o_ready` = !full, derived from registered occupancy only. While full, a pop in the same cycle does not raise `o_ready` until the following cycle.
- Simultaneous push and pop: both occur and occupancy is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`; occupancy saturates at 0 and `FIFO_DEPTH` by construction.
- FSM states:
  - IDLE: `o_tx`=1. If FIFO not empty, pop the head into the shift register, drive `o_tx`=0, clear the baud counter, and go to START.
  - START: hold 0 for `CLKS_PER_BIT` cycles, then drive bit0, set bit index to 0, and go to DATA.
  - DATA: hold each bit for `CLKS_PER_BIT` cycles, LSB first. After bit 7's period, drive `o_tx`=1 and go to STOP.
  - STOP: hold 1 for `CLKS_PER_BIT` cycles. At the end of the period:
    - If the FIFO is not empty, pop and drive a start bit immediately, with no extra idle cycle, and go to START.
    - Otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1; the bit ends on the terminal count.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles.
- `o_busy` = (state != IDLE) || (count != 0).
- Reset mid-frame: at the reset edge, `o_tx` returns to 1, the FIFO empties, and the partial frame is abandoned. No stop bit is completed.

## Timing
- Latency: a push at edge k into an empty FIFO with the FSM in IDLE gives `o_count`=1 after edge k and `o_tx`=0 after edge k+1. `o_count` then returns to 0 after edge k+1.
- The start bit falling edge lies 1 cycle after the accepting edge.
- Bit n (n=0..7) occupies cycles k+1+(n+1)·`CLKS_PER_BIT` .. k+(n+2)·`CLKS_PER_BIT`.
- Stop bit ends at k+1+10·`CLKS_PER_BIT`.
- Back-to-back frames: line falls to the next start bit on the cycle immediately after the stop period.
- Sustained throughput is one byte per 10·`CLKS_PER_BIT` cycles.
- `o_tx` is glitch-free: driven directly from a flop.

## Test plan
- Reset: assert `i_rst` for 2 cycles with `i_valid`=1 → `o_tx`=1, `o_ready`=1, `o_count`=0, `o_busy`=0; nothing is enqueued.
- Single byte, `CLKS_PER_BIT`=4: push 0x55 at edge k → `o_tx` low for cycles k+1..k+4, then 1,0,1,0,1,0,1,0 each held 4 cycles, then stop high 4 cycles. `o_busy` falls after edge k+41.
- Burst fill, `FIFO_DEPTH`=4: hold `i_valid`=1 for 6 cycles with 0xA0..0xA5 → 0xA0 pops immediately and 0xA1..0xA4 fill the FIFO; `o_ready` drops, 0xA5 is not accepted. Line shows 0xA0..0xA4 back-to-back with no idle gap between stop and start bits.
- Reset mid-frame: push 0x0F, assert `i_rst` during bit 3 → `o_tx`=1 on the next cycle and stays high; `o_count`=0. A new push of 0x3C afterwards transmits correctly.
- Data sweep: push 0x00..0xFF with `CLKS_PER_BIT`=104 into a bench UART receiver sampling at mid-bit → all 256 bytes received in order, stop bit always 1, no framing errors.

Source files
------------

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, small FIFO, LSB-first
// serialiser with a fixed clock divisor and a flop-driven line output.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;
  logic [BAUD_W-1:0]   baud;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                tx;
  logic                baud_end;
  logic                push;
  logic                pop;

  assign baud_end = (baud == BAUD_LAST);
  assign o_ready  = (count != FULL_CNT);
  assign push     = i_valid && o_ready;
  // The FSM takes the head either from IDLE or straight out of a finished stop bit.
  assign pop      = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_end));
  assign o_count  = count;
  assign o_busy   = (state != IDLE) || (count != '0);
  assign o_tx     = tx;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            tx    <= 1'b0;
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[DATA_W-1:1]};
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            // Chain straight into the next start bit so queued bytes leave no idle gap.
            if (pop) begin
              shreg <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a short bit period; a free-running line
// monitor decodes frames at mid-bit while scenario tasks drive and compare.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic       rx_stop[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_count (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: cycle of the first low sample is the frame start.
  initial begin
    logic [7:0] d;
    int         s;
    d = '0;
    forever begin
      tick();
      if (tx === 1'b0 && rst === 1'b0) begin
        s = cyc;
        repeat (CPB / 2) tick();
        for (int n = 0; n < 8; n++) begin
          repeat (CPB) tick();
          d[n] = tx;
        end
        repeat (CPB) tick();
        rx_q.push_back(d);
        rx_start.push_back(s);
        rx_stop.push_back(tx);
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
    rx_stop.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    repeat (CPB * 12) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
    clear_rx();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data = 8'hAA;
    tick();
    tick();
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (count !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0)  begin errors++; $display("FAIL reset_no_enqueue: count %0d want 0", count); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_no_frame: busy %b want 0", busy); end
  endtask

  task automatic test_single_byte();
    logic [40:0] exp_line;
    exp_line = 41'b1_1111_0000_1111_0000_1111_0000_1111_0000_1111_0000;
    wait_idle();
    valid = 1'b1; data = 8'h55;
    tick();
    valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_push: got %0d want 1", count); end
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL single_tx_push: got %b want 1", tx); end
    for (int c = 1; c <= 41; c++) begin
      tick();
      checks++;
      if (tx !== exp_line[c-1]) begin
        errors++;
        $display("FAIL single_line k+%0d: got %b want %b", c, tx, exp_line[c-1]);
      end
      if (c == 1) begin
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_pop: got %0d want 0", count); end
      end
      if (c == 40) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k40: got %b want 1", busy); end
      end
      if (c == 41) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_k41: got %b want 0", busy); end
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_rx: frames %0d first %h want 1 frame 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_cnt[6];
    logic       exp_rdy[6];
    int         k;
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    k = 0;
    wait_idle();
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 8'(8'hA0 + i);
      tick();
      if (i == 0) k = cyc;
      checks++;
      if (count !== exp_cnt[i] || ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL burst_fill[%0d]: count %0d ready %b want count %0d ready %b", i, count, ready, exp_cnt[i], exp_rdy[i]);
      end
    end
    valid = 1'b0;
    while (cyc < k + 40) tick();
    checks++;
    if (count !== 3'd4 || ready !== 1'b0) begin
      errors++; $display("FAIL burst_full_k40: count %0d ready %b want 4 0", count, ready);
    end
    tick();
    checks++;
    if (count !== 3'd3 || ready !== 1'b1) begin
      errors++; $display("FAIL burst_pop_k41: count %0d ready %b want 3 1", count, ready);
    end
    wait_frames(5, 400);
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL burst_frames: got %0d want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== 8'(8'hA0 + i) || rx_stop[i] !== 1'b1) begin
          errors++; $display("FAIL burst_byte[%0d]: got %h stop %b want %h stop 1", i, rx_q[i], rx_stop[i], 8'(8'hA0 + i));
        end
        checks++;
        if (i == 0 && rx_start[0] != k + 1) begin
          errors++; $display("FAIL burst_first_start: cycle %0d want %0d", rx_start[0], k + 1);
        end else if (i > 0 && rx_start[i] - rx_start[i-1] != 10 * CPB) begin
          errors++; $display("FAIL burst_gap[%0d]: spacing %0d want %0d", i, rx_start[i] - rx_start[i-1], 10 * CPB);
        end
      end
    end
    repeat (60) tick();
    checks++;
    if (rx_q.size() != 5 || busy !== 1'b0) begin
      errors++; $display("FAIL burst_drop_a5: frames %0d busy %b want 5 0", rx_q.size(), busy);
    end
  endtask

  task automatic test_reset_midframe();
    wait_idle();
    valid = 1'b1; data = 8'h0F;
    tick();
    valid = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    tick();
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_hold[%0d]: tx %b busy %b want 1 0", c, tx, busy);
      end
    end
    clear_rx();
    valid = 1'b1; data = 8'h3C;
    tick();
    valid = 1'b0;
    wait_frames(1, 100);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || rx_stop[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_recover: frames %0d byte %h want 1 frame 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_sweep();
    logic acc;
    int   w;
    wait_idle();
    for (int b = 0; b < 256; b++) begin
      valid = 1'b1; data = 8'(b);
      w = 0;
      do begin
        acc = ready;
        tick();
        w++;
      end while (!acc && w < 200);
    end
    valid = 1'b0;
    wait_frames(256, 11000);
    checks++;
    if (rx_q.size() != 256) begin
      errors++; $display("FAIL sweep_frames: got %0d want 256", rx_q.size());
    end else begin
      for (int b = 0; b < 256; b++) begin
        checks++;
        if (rx_q[b] !== 8'(b) || rx_stop[b] !== 1'b1) begin
          errors++; $display("FAIL sweep_byte[%0d]: got %h stop %b want %h stop 1", b, rx_q[b], rx_stop[b], 8'(b));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_midframe();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
